// File: rtl/fantasticfft_pkg.sv
// fantasticfft_pkg: shared fixed-point types, FFT constants and output FSM states.
package fantasticfft_pkg;
    localparam int FFT_N        = 8;
    localparam int FFT_LOG2     = 3;
    localparam int FIXED_INT_W  = 8;
    localparam int FIXED_FRAC_W = 8;
    localparam int FIXED_W      = FIXED_INT_W + FIXED_FRAC_W;

    typedef logic signed [FIXED_W-1:0] fixed_t;

    typedef struct packed {
        fixed_t re;
        fixed_t im;
    } complex_t;

    typedef enum logic {ST_IDLE, ST_STREAM} unl_state_t;
endpackage

// File: rtl/fantasticfft_fft8_unloader_if.sv
// fantasticfft_fft8_unloader_if: frame-parallel FFT input and sample-serial valid/ready output bundle.
interface fantasticfft_fft8_unloader_if #(parameter int DATA_W = 16);
    import fantasticfft_pkg::*;
    logic                     in_valid;
    logic signed [DATA_W-1:0] in_re [FFT_N];
    logic signed [DATA_W-1:0] in_im [FFT_N];
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_re;
    logic signed [DATA_W-1:0] out_im;
    logic [2:0]               out_index;
    logic                     out_last;
    logic                     overflow;
    logic                     busy;

    modport slave (
        input  in_valid, in_re, in_im, out_ready,
        output out_valid, out_re, out_im, out_index, out_last, overflow, busy
    );

    modport master (
        output in_valid, in_re, in_im, out_ready,
        input  out_valid, out_re, out_im, out_index, out_last, overflow, busy
    );
endinterface

// File: rtl/fantasticfft_frame_buf.sv
// fantasticfft_frame_buf: 8-entry complex register bank, write-all in one cycle, indexed read.
module fantasticfft_frame_buf
    import fantasticfft_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic signed [DATA_W-1:0] i_re [FFT_N],
    input  logic signed [DATA_W-1:0] i_im [FFT_N],
    input  logic [2:0]               i_idx,
    output logic signed [DATA_W-1:0] o_re,
    output logic signed [DATA_W-1:0] o_im
);
    logic signed [DATA_W-1:0] r_re [FFT_N];
    logic signed [DATA_W-1:0] r_im [FFT_N];

    // Data needs no reset: the owner's full flags decide whether it is meaningful.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_re <= i_re;
            r_im <= i_im;
        end
    end

    assign o_re = r_re[i_idx];
    assign o_im = r_im[i_idx];
endmodule

// File: rtl/fantasticfft_fft8_unloader.sv
// fantasticfft_fft8_unloader: ping-pong buffers FFT frames and streams them one sample per cycle.
// Define FANTASTICFFT_OUT_SCALE_EN to scale outputs by 1/N with round-half-up.
module fantasticfft_fft8_unloader
    import fantasticfft_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8
) (
    input logic clk,
    input logic rst,
    fantasticfft_fft8_unloader_if.slave bus
);
    if (FRAC_W >= DATA_W) begin : g_bad_frac
        $error("FRAC_W must be smaller than DATA_W");
    end

    unl_state_t               r_state;
    unl_state_t               w_state_nx;
    logic [1:0]               r_full;
    logic [1:0]               w_full_nx;
    logic                     r_wp;
    logic                     r_rp;
    logic [2:0]               r_cnt;
    logic                     r_ovf;
    logic                     w_valid;
    logic                     w_hs;
    logic                     w_rel;
    logic                     w_wfree;
    logic                     w_cap;
    logic signed [DATA_W-1:0] w_re [2];
    logic signed [DATA_W-1:0] w_im [2];
    logic signed [DATA_W-1:0] w_sel_re;
    logic signed [DATA_W-1:0] w_sel_im;
    logic signed [DATA_W-1:0] w_out_re;
    logic signed [DATA_W-1:0] w_out_im;

    assign w_valid = (r_state == ST_STREAM);
    assign w_hs    = w_valid & bus.out_ready;
    assign w_rel   = w_hs & (r_cnt == 3'd7);
    // A buffer released at this edge may be refilled at the same edge.
    assign w_wfree = ~r_full[r_wp] | (w_rel & (r_rp == r_wp));
    assign w_cap   = bus.in_valid & w_wfree;

    for (genvar g = 0; g < 2; g++) begin : g_buf
        fantasticfft_frame_buf #(.DATA_W(DATA_W)) u_buf (
            .clk   (clk),
            .i_we  (w_cap & (r_wp == 1'(g))),
            .i_re  (bus.in_re),
            .i_im  (bus.in_im),
            .i_idx (r_cnt),
            .o_re  (w_re[g]),
            .o_im  (w_im[g])
        );
    end

    always_comb begin
        w_full_nx = '0;
        for (int b = 0; b < 2; b++)
            w_full_nx[b] = (r_full[b] & ~(w_rel & (r_rp == 1'(b)))) | (w_cap & (r_wp == 1'(b)));
    end

    // Looking at next-cycle fullness keeps back-to-back frames bubble-free.
    always_comb begin
        w_state_nx = (r_state == ST_IDLE) ? (r_full[r_rp] ? ST_STREAM : ST_IDLE)
                   : (w_rel ? (w_full_nx[~r_rp] ? ST_STREAM : ST_IDLE) : ST_STREAM);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_full  <= '0;
            r_wp    <= 1'b0;
            r_rp    <= 1'b0;
            r_cnt   <= 3'd0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_full  <= w_full_nx;
            if (w_cap) r_wp <= ~r_wp;
            if (w_rel) r_rp <= ~r_rp;
            if (w_hs) r_cnt <= r_cnt + 3'd1;
            if (bus.in_valid & ~w_wfree) r_ovf <= 1'b1;
        end
    end

    assign w_sel_re = r_rp ? w_re[1] : w_re[0];
    assign w_sel_im = r_rp ? w_im[1] : w_im[0];

`ifdef FANTASTICFFT_OUT_SCALE_EN
    logic signed [DATA_W:0] w_rnd_re;
    logic signed [DATA_W:0] w_rnd_im;

    // One guard bit keeps the rounding add from wrapping near full scale.
    assign w_rnd_re = $signed({w_sel_re[DATA_W-1], w_sel_re}) + $signed((DATA_W+1)'(1 << (FFT_LOG2 - 1)));
    assign w_rnd_im = $signed({w_sel_im[DATA_W-1], w_sel_im}) + $signed((DATA_W+1)'(1 << (FFT_LOG2 - 1)));
    assign w_out_re = DATA_W'(w_rnd_re >>> FFT_LOG2);
    assign w_out_im = DATA_W'(w_rnd_im >>> FFT_LOG2);
`else
    assign w_out_re = w_sel_re;
    assign w_out_im = w_sel_im;
`endif

    assign bus.out_valid = w_valid;
    assign bus.out_re    = w_valid ? w_out_re : '0;
    assign bus.out_im    = w_valid ? w_out_im : '0;
    assign bus.out_index = w_valid ? r_cnt : 3'd0;
    assign bus.out_last  = w_valid & (r_cnt == 3'd7);
    assign bus.overflow  = r_ovf;
    assign bus.busy      = |r_full;
endmodule

// File: tb/tb_fantasticfft_fft8_unloader.sv
// tb_fantasticfft_fft8_unloader: randomized and directed checks against a frame-queue reference model.
module tb_fantasticfft_fft8_unloader;
    logic clk = 1'b0;
    logic rst = 1'b1;

    fantasticfft_fft8_unloader_if #(.DATA_W(16)) bus ();

    fantasticfft_fft8_unloader #(.DATA_W(16), .FRAC_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk   = 0;
    int n_pass  = 0;
    int n_beats = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int scl(input int x);
`ifdef FANTASTICFFT_OUT_SCALE_EN
        int t;
        t = x + 4;
        return (t - (((t % 8) + 8) % 8)) / 8;
`else
        return x;
`endif
    endfunction

    // Reference: a queue of pending samples plus a count of frames held (at most two).
    logic [31:0] sq[$];
    int          m_frames = 0;
    int          m_beat   = 0;
    bit          m_stream = 0;
    bit          m_ovf    = 0;

    task automatic model_step();
        bit hs, rel, was;
        if (rst) begin
            sq.delete();
            m_frames = 0;
            m_beat   = 0;
            m_stream = 0;
            m_ovf    = 0;
        end else begin
            hs  = m_stream && bus.out_ready;
            rel = hs && (m_beat == 7);
            was = m_frames > 0;
            if (hs) begin
                void'(sq.pop_front());
                m_beat = (m_beat + 1) % 8;
            end
            if (rel) m_frames--;
            if (bus.in_valid) begin
                if (m_frames < 2) begin
                    for (int i = 0; i < 8; i++) sq.push_back({bus.in_re[i], bus.in_im[i]});
                    m_frames++;
                end else m_ovf = 1;
            end
            m_stream = m_stream ? (rel ? (m_frames > 0) : 1'b1) : was;
        end
    endtask

    task automatic compare_outputs();
        check("valid", int'(bus.out_valid), int'(m_stream));
        check("overflow", int'(bus.overflow), int'(m_ovf));
        check("busy", int'(bus.busy), int'(m_frames > 0));
        if (m_stream && sq.size() > 0) begin
            check("re", int'(bus.out_re), scl(int'($signed(sq[0][31:16]))));
            check("im", int'(bus.out_im), scl(int'($signed(sq[0][15:0]))));
            check("index", int'(bus.out_index), m_beat);
            check("last", int'(bus.out_last), int'(m_beat == 7));
        end
        if (bus.out_valid && bus.out_ready) n_beats++;
    endtask

    always @(posedge clk or posedge rst) model_step();
    always @(negedge clk) if (!rst) compare_outputs();

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ramp();
        int rim[8] = '{0, 2472, 1024, 424, 0, -424, -1024, -2472};
        for (int i = 0; i < 8; i++) begin
            bus.in_re[i] = (i == 0) ? 16'sh2400 : 16'shFC00;
            bus.in_im[i] = 16'(rim[i]);
        end
    endtask

    task automatic load_rand();
        for (int i = 0; i < 8; i++) begin
            bus.in_re[i] = 16'($urandom);
            bus.in_im[i] = 16'($urandom);
        end
    endtask

    task automatic send();
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idx(input int idx);
        for (int i = 0; i < 60; i++) begin
            if (bus.out_valid && bus.out_index == 3'(idx)) break;
            tick();
        end
        check("reach_valid", int'(bus.out_valid), 1);
        check("reach_index", int'(bus.out_index), idx);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, int'(bus.out_valid), 0);
        check({tag, "_re"}, int'(bus.out_re), 0);
        check({tag, "_im"}, int'(bus.out_im), 0);
        check({tag, "_index"}, int'(bus.out_index), 0);
        check({tag, "_last"}, int'(bus.out_last), 0);
        check({tag, "_overflow"}, int'(bus.overflow), 0);
        check({tag, "_busy"}, int'(bus.busy), 0);
    endtask

    initial begin
        int cnt;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        load_ramp();
        // Reset held for two cycles
        tick();
        tick();
        check_reset_outputs("rst");
        rst = 1'b0;
        repeat (3) tick();
        check("idle_valid", int'(bus.out_valid), 0);

        // Single ramp frame, ready high
        bus.out_ready = 1'b1;
        load_ramp();
        send();
        check("lat_edge_k", int'(bus.out_valid), 0);
        tick();
        check("lat_valid", int'(bus.out_valid), 1);
        check("idx0_index", int'(bus.out_index), 0);
        check("idx0_re", int'(bus.out_re), scl(9216));
        check("idx0_im", int'(bus.out_im), scl(0));
        cnt = 1;
        for (int i = 0; i < 11; i++) begin
            tick();
            if (bus.out_valid) begin
                cnt++;
                if (bus.out_index == 3'd2) begin
                    check("idx2_re", int'(bus.out_re), scl(-1024));
                    check("idx2_im", int'(bus.out_im), scl(1024));
                end
                if (bus.out_index == 3'd4) check("idx4_re", int'(bus.out_re), scl(-1024));
                check("last_only_idx7", int'(bus.out_last), int'(bus.out_index == 3'd7));
            end
        end
        check("frame_beats", cnt, 8);

        // Backpressure at idx2
        load_rand();
        send();
        wait_idx(2);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_index", int'(bus.out_index), 2);
            check("bp_hold_valid", int'(bus.out_valid), 1);
        end
        bus.out_ready = 1'b1;
        tick();
        check("bp_resume_index", int'(bus.out_index), 3);
        repeat (10) tick();

        // Capture into the buffer released at the same edge
        n_beats = 0;
        load_rand();
        send();
        load_rand();
        send();
        wait_idx(7);
        load_rand();
        send();
        repeat (30) tick();
        check("sim_beats", n_beats, 24);
        check("sim_overflow", int'(bus.overflow), 0);
        check("sim_busy", int'(bus.busy), 0);

        // Overflow: three frames with no drain
        bus.out_ready = 1'b0;
        load_rand();
        send();
        load_rand();
        send();
        check("ovf_two_frames", int'(bus.overflow), 0);
        load_rand();
        send();
        check("ovf_third_frame", int'(bus.overflow), 1);
        n_beats = 0;
        bus.out_ready = 1'b1;
        repeat (16) tick();
        check("ovf_beats_no_gap", n_beats, 16);
        repeat (4) tick();
        check("ovf_beats_total", n_beats, 16);
        check("ovf_sticky", int'(bus.overflow), 1);

        // Randomized traffic and backpressure
        for (int i = 0; i < 400; i++) begin
            load_rand();
            bus.in_valid  = ($urandom % 5) == 0;
            bus.out_ready = ($urandom % 4) != 0;
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (30) tick();

        // Reset mid-stream at idx4
        load_ramp();
        send();
        wait_idx(4);
        #1 rst = 1'b1;
        #1 check_reset_outputs("mid_rst");
        tick();
        rst = 1'b0;
        load_ramp();
        send();
        tick();
        check("rerun_valid", int'(bus.out_valid), 1);
        check("rerun_idx0_re", int'(bus.out_re), scl(9216));
        repeat (12) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
